// File: rtl/ub_pkg.sv
// Shared definitions for the unified-buffer access blocks: read-sequencer
// state encoding and address/index width helpers.
package ub_pkg;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_DRAIN,
        RD_OUT,
        RD_FIN
    } ub_rd_state_e;

    // Full byte-address width: word address, bank select and byte-in-word.
    function automatic int unsigned ub_addr_width(input int unsigned addr_width,
                                                  input int unsigned no_banks,
                                                  input int unsigned sa_length);
        return addr_width + $clog2(no_banks) + $clog2(sa_length);
    endfunction

    // Width of a byte index inside one SA_LENGTH-byte vector.
    function automatic int unsigned ub_idx_width(input int unsigned sa_length);
        return (sa_length > 1) ? $clog2(sa_length) : 1;
    endfunction

endpackage

// File: rtl/ub_vector_reader_if.sv
// Command, buffer-read and vector-output signals of the unified-buffer
// vector reader. The master side is the reader itself; the slave side is
// the surrounding system (controller queue, buffer and array feeder).
interface ub_vector_reader_if #(
    parameter int unsigned SA_LENGTH  = 256,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NO_BANKS   = 8,
    parameter int unsigned LEN_WIDTH  = 16
);
    import ub_pkg::*;

    localparam int unsigned AddrWidth = ub_addr_width(ADDR_WIDTH, NO_BANKS, SA_LENGTH);

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [AddrWidth-1:0]     cmd_addr;
    logic [LEN_WIDTH-1:0]     cmd_len;
    logic                     ub_rd_active;
    logic [AddrWidth-1:0]     ub_rdaddr;
    logic [7:0]               ub_rddata;
    logic                     vec_valid;
    logic                     vec_ready;
    logic [8*SA_LENGTH-1:0]   vec_data;
    logic                     vec_last;
    logic                     busy;
    logic                     done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ub_rddata, vec_ready,
        output cmd_ready, ub_rd_active, ub_rdaddr, vec_valid, vec_data, vec_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ub_rddata, vec_ready,
        input  cmd_ready, ub_rd_active, ub_rdaddr, vec_valid, vec_data, vec_last, busy, done
    );

endinterface

// File: rtl/ub_byte_assembler.sv
// Byte-indexed capture register that builds one SA_LENGTH-byte vector from
// the buffer's byte-wide read data. Byte j lands in bits [8j+:8].
module ub_byte_assembler
    import ub_pkg::*;
#(
    parameter int unsigned SA_LENGTH = 256
) (
    input  logic                                  CLK,
    input  logic                                  ASYNC_RST,
    input  logic                                  clr_i,
    input  logic                                  we_i,
    input  logic [ub_idx_width(SA_LENGTH)-1:0]    idx_i,
    input  logic [7:0]                            byte_i,
    output logic [8*SA_LENGTH-1:0]                data_o
);

    logic [SA_LENGTH-1:0][7:0] data_q;

    // Clear has priority over a capture in the same cycle.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q[idx_i] <= byte_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/ub_vector_reader.sv
// Read-side sequencer for the unified buffer: walks the byte-wide read port
// one byte per cycle, absorbs the one-cycle read latency, and hands each
// assembled vector to the systolic-array feeder over valid/ready.
module ub_vector_reader
    import ub_pkg::*;
#(
    parameter int unsigned SA_LENGTH  = 256,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NO_BANKS   = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic               CLK,
    input  logic               ASYNC_RST,
    input  logic               SYNC_RST,
    ub_vector_reader_if.master bus
);

    localparam int unsigned AddrWidth = ub_addr_width(ADDR_WIDTH, NO_BANKS, SA_LENGTH);
    localparam int unsigned IdxWidth  = ub_idx_width(SA_LENGTH);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(SA_LENGTH - 1);

    ub_rd_state_e           state_q;
    logic [AddrWidth-1:0]   cur_addr_q;
    logic [AddrWidth-1:0]   rdaddr_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [IdxWidth-1:0]    j_q;
    logic                   cmd_ready_q;
    logic                   rd_active_q;
    logic                   vec_valid_q;
    logic                   vec_last_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   cap_we;
    logic [IdxWidth-1:0]    cap_idx;
    logic [8*SA_LENGTH-1:0] vec_data_w;

    // Read data trails the address by one cycle, so each ISSUE edge after the
    // first stores the previous byte and the DRAIN edge stores the last one.
    always_comb begin
        cap_we  = 1'b0;
        cap_idx = '0;
        if (state_q == RD_ISSUE && j_q != '0) begin
            cap_we  = 1'b1;
            cap_idx = j_q - IdxWidth'(1);
        end else if (state_q == RD_DRAIN) begin
            cap_we  = 1'b1;
            cap_idx = LastIdx;
        end
    end

    ub_byte_assembler #(
        .SA_LENGTH (SA_LENGTH)
    ) u_assembler (
        .CLK       (CLK),
        .ASYNC_RST (ASYNC_RST),
        .clr_i     (SYNC_RST),
        .we_i      (cap_we),
        .idx_i     (cap_idx),
        .byte_i    (bus.ub_rddata),
        .data_o    (vec_data_w)
    );

    // Command sequencing with registered outputs. cur_addr_q always runs one
    // byte ahead of rdaddr_q, so after the last ISSUE edge it already holds the
    // start of the next contiguous vector while rdaddr_q holds its last value.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q     <= RD_IDLE;
            cur_addr_q  <= '0;
            rdaddr_q    <= '0;
            rem_q       <= '0;
            j_q         <= '0;
            cmd_ready_q <= 1'b1;
            rd_active_q <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (SYNC_RST) begin
            state_q     <= RD_IDLE;
            cur_addr_q  <= '0;
            rdaddr_q    <= '0;
            rem_q       <= '0;
            j_q         <= '0;
            cmd_ready_q <= 1'b1;
            rd_active_q <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                RD_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rem_q       <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            state_q    <= RD_FIN;
                            done_q     <= 1'b1;
                            cur_addr_q <= bus.cmd_addr;
                        end else begin
                            state_q     <= RD_ISSUE;
                            j_q         <= '0;
                            rd_active_q <= 1'b1;
                            rdaddr_q    <= bus.cmd_addr;
                            cur_addr_q  <= bus.cmd_addr + AddrWidth'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    j_q <= j_q + IdxWidth'(1);
                    if (j_q == LastIdx) begin
                        state_q     <= RD_DRAIN;
                        rd_active_q <= 1'b0;
                    end else begin
                        rdaddr_q   <= cur_addr_q;
                        cur_addr_q <= cur_addr_q + AddrWidth'(1);
                    end
                end
                RD_DRAIN: begin
                    state_q     <= RD_OUT;
                    vec_valid_q <= 1'b1;
                    vec_last_q  <= (rem_q == LEN_WIDTH'(1));
                end
                RD_OUT: begin
                    if (bus.vec_ready) begin
                        vec_valid_q <= 1'b0;
                        vec_last_q  <= 1'b0;
                        rem_q       <= rem_q - LEN_WIDTH'(1);
                        if (rem_q == LEN_WIDTH'(1)) begin
                            state_q <= RD_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= RD_ISSUE;
                            j_q         <= '0;
                            rd_active_q <= 1'b1;
                            rdaddr_q    <= cur_addr_q;
                            cur_addr_q  <= cur_addr_q + AddrWidth'(1);
                        end
                    end
                end
                RD_FIN: begin
                    state_q     <= RD_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.ub_rd_active = rd_active_q;
    assign bus.ub_rdaddr    = rdaddr_q;
    assign bus.vec_valid    = vec_valid_q;
    assign bus.vec_data     = vec_data_w;
    assign bus.vec_last     = vec_last_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_ub_vector_reader.sv
// Scoreboard bench for ub_vector_reader with a 4-byte vector, 5-bit byte
// address configuration and a behavioural buffer holding byte[a] = a + 0x10.
module tb_ub_vector_reader;

    localparam int unsigned SAL = 4;
    localparam int unsigned AW  = 2;
    localparam int unsigned NB  = 2;
    localparam int unsigned LW  = 16;

    logic CLK = 1'b0;
    logic ASYNC_RST;
    logic SYNC_RST;

    always #5 CLK = ~CLK;

    ub_vector_reader_if #(.SA_LENGTH(SAL), .ADDR_WIDTH(AW), .NO_BANKS(NB), .LEN_WIDTH(LW)) bus ();

    ub_vector_reader #(.SA_LENGTH(SAL), .ADDR_WIDTH(AW), .NO_BANKS(NB), .LEN_WIDTH(LW)) dut (
        .CLK       (CLK),
        .ASYNC_RST (ASYNC_RST),
        .SYNC_RST  (SYNC_RST),
        .bus       (bus)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    int cyc      = 0;
    int e0       = 0;
    int done_cyc = 0;
    int hs_cyc   = 0;
    int done_exp = 0;
    int ready_mode = 0;   // 0: ready high, 1: random, 2: held low

    logic [4:0]  addr_q[$];
    logic [32:0] vec_q[$];
    int          rd_rise_q[$];
    int          rise_q[$];
    logic        rd_prev = 1'b0;
    logic        vv_prev = 1'b0;
    logic [32:0] exp_vec;

    function automatic logic [7:0] ub_byte(input logic [4:0] a);
        return 8'(a) + 8'h10;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic note_fail(input string name, input string detail);
        total++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic flush();
        addr_q.delete();
        vec_q.delete();
        done_exp = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cmd_ready"},    64'(bus.cmd_ready),    64'(1));
        chk({tag, "_rd_active"},    64'(bus.ub_rd_active), 64'(0));
        chk({tag, "_rdaddr"},       64'(bus.ub_rdaddr),    64'(0));
        chk({tag, "_vec_valid"},    64'(bus.vec_valid),    64'(0));
        chk({tag, "_vec_data"},     64'(bus.vec_data),     64'(0));
        chk({tag, "_vec_last"},     64'(bus.vec_last),     64'(0));
        chk({tag, "_busy"},         64'(bus.busy),         64'(0));
        chk({tag, "_done"},         64'(bus.done),         64'(0));
    endtask

    // Buffer model: registered read, enabled by ub_rd_active.
    always @(posedge CLK) begin
        if (bus.ub_rd_active) bus.ub_rddata <= ub_byte(bus.ub_rdaddr);
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Consumer ready driver.
    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            0:       bus.vec_ready = 1'b1;
            1:       bus.vec_ready = 1'($urandom_range(0, 1));
            default: bus.vec_ready = 1'b0;
        endcase
    end

    // Monitor: pops expected reads, vectors and done pulses as the DUT shows them.
    always @(negedge CLK) begin
        if (!ASYNC_RST || SYNC_RST) begin
            rd_prev = 1'b0;
            vv_prev = 1'b0;
        end else begin
            if (bus.ub_rd_active) begin
                if (!rd_prev) rd_rise_q.push_back(cyc);
                if (addr_q.size() == 0)
                    note_fail("rdaddr", $sformatf("got read of 0x%0h, required no read", bus.ub_rdaddr));
                else
                    chk("rdaddr", 64'(bus.ub_rdaddr), 64'(addr_q.pop_front()));
            end
            if (bus.vec_valid && !vv_prev) rise_q.push_back(cyc);
            if (bus.vec_valid && bus.ub_rd_active)
                note_fail("rd_during_out", "got ub_rd_active=1 with vec_valid=1, required 0");
            if (bus.vec_valid && bus.vec_ready) begin
                hs_cyc = cyc;
                if (vec_q.size() == 0) begin
                    note_fail("vec", $sformatf("got vector 0x%0h, required none", bus.vec_data));
                end else begin
                    exp_vec = vec_q.pop_front();
                    chk("vec_data", 64'(bus.vec_data), 64'(exp_vec[31:0]));
                    chk("vec_last", 64'(bus.vec_last), 64'(exp_vec[32]));
                end
            end
            if (bus.done) begin
                if (done_exp == 0) begin
                    note_fail("done", "got done=1, required no done pulse");
                end else begin
                    chk("done_state", 64'({bus.cmd_ready, bus.busy}), 64'(2'b01));
                    done_exp--;
                    done_cyc = cyc;
                end
            end
            rd_prev = bus.ub_rd_active;
            vv_prev = bus.vec_valid;
        end
    end

    // Reference model: vector k of a command is bytes cmd_addr + k*SAL + b, mod 32.
    task automatic start_cmd(input logic [4:0] a, input int unsigned len);
        int n;
        logic [31:0] d;
        logic [4:0]  ba;
        n = 0;
        for (int unsigned k = 0; k < len; k++) begin
            d = '0;
            for (int unsigned b = 0; b < SAL; b++) begin
                ba = a + 5'(k * SAL + b);
                addr_q.push_back(ba);
                d[8*b +: 8] = ub_byte(ba);
            end
            vec_q.push_back({(k == len - 1), d});
        end
        done_exp++;
        rd_rise_q.delete();
        rise_q.delete();
        while (!bus.cmd_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = LW'(len);
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        e0 = cyc - 1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_exp != 0 && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        if (done_exp != 0) begin
            note_fail("done_timeout", "got no done within 400 cycles, required done");
            flush();
        end
        chk("done_one_cycle",       64'(bus.done),      64'(0));
        chk("cmd_ready_after_done", 64'(bus.cmd_ready), 64'(1));
        chk("ready_cycle",          64'(cyc),           64'(done_cyc + 1));
        chk("reads_outstanding",    64'(addr_q.size()), 64'(0));
        chk("vecs_outstanding",     64'(vec_q.size()),  64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required $finish");
        $fatal(1);
    end

    initial begin
        int n;
        ASYNC_RST     = 1'b0;
        SYNC_RST      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        repeat (3) @(posedge CLK);
        #1;
        ASYNC_RST = 1'b1;
        @(posedge CLK); #1;
        check_idle("reset");

        // Single vector from address 0.
        start_cmd(5'd0, 1);
        wait_done();
        chk("t1_first_read_cycle", 64'((rd_rise_q.size() > 0) ? rd_rise_q[0] - e0 : -1), 64'(1));
        chk("t1_valid_cycle",      64'((rise_q.size() > 0) ? rise_q[0] - e0 : -1),       64'(6));
        chk("t1_done_after_hs",    64'(done_cyc - hs_cyc), 64'(1));

        // Three contiguous vectors with ready held high.
        start_cmd(5'd4, 3);
        wait_done();
        chk("t2_vector_count", 64'(rise_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_valid_cycle_%0d", i),
                64'((rise_q.size() > i) ? rise_q[i] - e0 : -1), 64'(6 + 6 * i));
            chk($sformatf("t2_read_cycle_%0d", i),
                64'((rd_rise_q.size() > i) ? rd_rise_q[i] - e0 : -1), 64'(1 + 6 * i));
        end

        // Address wrap-around.
        start_cmd(5'd30, 1);
        wait_done();

        // Backpressure: vec_ready low for 10 cycles of OUT.
        ready_mode = 2;
        fork
            begin
                start_cmd(5'd12, 1);
                wait_done();
            end
            begin
                n = 0;
                @(negedge CLK);
                while (!bus.vec_valid && n < 200) begin
                    @(negedge CLK);
                    n++;
                end
                if (!bus.vec_valid) begin
                    note_fail("bp_valid", "got vec_valid=0 after 200 cycles, required 1");
                end else begin
                    for (int i = 0; i < 10; i++) begin
                        if (i > 0) @(negedge CLK);
                        chk("bp_valid",     64'(bus.vec_valid),    64'(1));
                        chk("bp_rd_active", 64'(bus.ub_rd_active), 64'(0));
                        chk("bp_rdaddr",    64'(bus.ub_rdaddr),    64'(15));
                        chk("bp_data",      64'(bus.vec_data),     64'(32'h1F1E1D1C));
                    end
                end
                ready_mode = 0;
            end
        join
        chk("bp_accept_cycle", 64'(hs_cyc - e0), 64'(16));

        // Zero-length command.
        start_cmd(5'd7, 0);
        wait_done();
        chk("len0_done_cycle",  64'(done_cyc - e0),      64'(1));
        chk("len0_ready_cycle", 64'(cyc - e0),           64'(2));
        chk("len0_no_reads",    64'(rd_rise_q.size()),   64'(0));

        // Synchronous abort during ISSUE of the second vector.
        start_cmd(5'd0, 3);
        n = 0;
        while (rd_rise_q.size() < 2 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("abort_reached_vec2", 64'(rd_rise_q.size()), 64'(2));
        SYNC_RST = 1'b1;
        @(posedge CLK); #1;
        SYNC_RST = 1'b0;
        flush();
        check_idle("sync_abort");
        repeat (4) begin
            @(posedge CLK); #1;
        end

        // Asynchronous abort while holding a vector in OUT.
        ready_mode = 2;
        start_cmd(5'd8, 2);
        n = 0;
        while (rise_q.size() < 1 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("abort_reached_out", 64'(bus.vec_valid), 64'(1));
        ASYNC_RST = 1'b0;
        #1;
        check_idle("async_abort");
        #2;
        ASYNC_RST = 1'b1;
        flush();
        ready_mode = 0;
        repeat (3) begin
            @(posedge CLK); #1;
        end

        // Normal command after the aborts.
        start_cmd(5'd5, 2);
        wait_done();

        // Randomized commands with random consumer readiness.
        ready_mode = 1;
        for (int t = 0; t < 20; t++) begin
            start_cmd(5'($urandom_range(0, 31)), $urandom_range(0, 3));
            wait_done();
        end
        ready_mode = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
